// File: rtl/line_rotate_scrambler_pkg.sv
// Shared types and helpers for the cut-and-rotate line scrambler.
package line_rotate_scrambler_pkg;

  localparam logic MODE_SCRAMBLE   = 1'b0;
  localparam logic MODE_DESCRAMBLE = 1'b1;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_FULL} wr_state_t;
  typedef enum logic       {R_IDLE, R_RUN}          rd_state_t;

  // Maps a key byte uniformly onto 0..line_len-1.
  function automatic int unsigned cut_point(input int unsigned key,
                                            input int unsigned line_len,
                                            input int unsigned key_w);
    return (key * line_len) >> key_w;
  endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Ping-pong line store: 2 banks x LINE_LEN samples, one write and one registered read port.
module line_buffer_dp #(
  parameter int DATA_W   = 10,
  parameter int LINE_LEN = 1440,
  parameter int ADDR_W   = $clog2(LINE_LEN)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2][LINE_LEN];

  // NOTE: the array and its read register carry no reset so the tools can map them to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/line_rotate_scrambler.sv
// Buffers each active line and replays it one line later, cyclically rotated by a key-derived cut.
module line_rotate_scrambler
  import line_rotate_scrambler_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int LINE_LEN = 1440,
  parameter int KEY_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              H,
  input  logic              V,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_in_valid,
  input  logic [KEY_W-1:0]  key,
  input  logic              key_valid,
  input  logic              mode,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_out_valid,
  output logic              key_miss,
  output logic              line_overrun
);

  localparam int                ADDR_W = $clog2(LINE_LEN);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(LINE_LEN - 1);

  wr_state_t         w_state;
  rd_state_t         r_state;
  logic              prev_h, prev_v;
  logic              wr_bank, line_ready, wrote_any, overrun_seen;
  logic [ADDR_W-1:0] wa, ra, rcnt;
  logic [ADDR_W-1:0] cut, start_ra;
  logic              line_start, h_rise, v_rise, wr_en, rd_en;
  logic [DATA_W-1:0] rd_data;

  assign line_start = prev_h & ~H & ~V;
  assign h_rise     = ~prev_h & H;
  assign v_rise     = ~prev_v & V;
  assign wr_en      = (w_state == W_FILL) & pix_in_valid & ~h_rise;
  assign rd_en      = (r_state == R_RUN) & line_ready & pix_in_valid & ~h_rise;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cut      = key_valid ? ADDR_W'(cut_point(32'(key), LINE_LEN, KEY_W)) : '0;
    start_ra = cut;
    if (mode == MODE_DESCRAMBLE && cut != '0) start_ra = ADDR_W'(LINE_LEN) - cut;
  end

  line_buffer_dp #(
    .DATA_W  (DATA_W),
    .LINE_LEN(LINE_LEN),
    .ADDR_W  (ADDR_W)
  ) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_bank(wr_bank),
    .wr_addr(wa),
    .wr_data(pix_in),
    .rd_en  (rd_en),
    .rd_bank(~wr_bank),
    .rd_addr(ra),
    .rd_data(rd_data)
  );

  // RAM data register has no reset; gate it so pix_out reads 0 whenever it is not valid.
  assign pix_out = pix_out_valid ? rd_data : '0;

  // NOTE: all state uses non-blocking assignments; later assignments in the block take priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state       <= W_IDLE;
      r_state       <= R_IDLE;
      prev_h        <= 1'b0;
      prev_v        <= 1'b0;
      wr_bank       <= 1'b0;
      line_ready    <= 1'b0;
      wrote_any     <= 1'b0;
      overrun_seen  <= 1'b0;
      wa            <= '0;
      ra            <= '0;
      rcnt          <= '0;
      pix_out_valid <= 1'b0;
      key_miss      <= 1'b0;
      line_overrun  <= 1'b0;
    end else begin
      prev_h        <= H;
      prev_v        <= V;
      pix_out_valid <= rd_en;
      key_miss      <= line_start & ~key_valid;
      line_overrun  <= 1'b0;

      if (line_start) begin
        w_state      <= W_FILL;
        wr_bank      <= ~wr_bank;
        wa           <= '0;
        line_ready   <= wrote_any;
        wrote_any    <= 1'b0;
        overrun_seen <= 1'b0;
      end else if (h_rise) begin
        w_state <= W_IDLE;
      end else begin
        case (w_state)
          W_FILL: if (pix_in_valid) begin
            wrote_any <= 1'b1;
            if (wa == LAST) w_state <= W_FULL;
            else            wa      <= wa + ADDR_W'(1);
          end
          W_FULL: if (pix_in_valid && !overrun_seen) begin
            line_overrun <= 1'b1;
            overrun_seen <= 1'b1;
          end
          default: ;
        endcase
      end

      // Data buffered before vertical blanking must never be replayed after it.
      if (v_rise) begin
        line_ready <= 1'b0;
        wrote_any  <= 1'b0;
      end

      if (line_start) begin
        r_state <= wrote_any ? R_RUN : R_IDLE;
        ra      <= start_ra;
        rcnt    <= '0;
      end else if (rd_en) begin
        ra   <= (ra == LAST) ? '0 : ra + ADDR_W'(1);
        rcnt <= rcnt + ADDR_W'(1);
        if (rcnt == LAST) r_state <= R_IDLE;
      end else if (h_rise) begin
        r_state <= R_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_line_rotate_scrambler.sv
// Scoreboard bench: stimulus pushes expected samples, negedge monitors pop and compare.
module tb_line_rotate_scrambler;

  localparam int DATA_W = 10;
  localparam int LEN    = 16;
  localparam int KEY_W  = 8;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              h = 1'b1, v = 1'b0;
  logic [DATA_W-1:0] pix_in = '0;
  logic              pix_in_valid = 1'b0;
  logic [KEY_W-1:0]  key = '0;
  logic              key_valid = 1'b0;
  logic              mode = 1'b0;
  logic              mode_b = 1'b1;
  logic [DATA_W-1:0] pix_out_a, pix_out_b;
  logic              pix_out_valid_a, pix_out_valid_b;
  logic              key_miss_a, key_miss_b, line_overrun_a, line_overrun_b;

  int   cyc = 0;
  int   checks = 0, errors = 0;
  exp_t sb_a[$];
  int   sb_b[$];
  int   next_exp[$];
  bit   chk_b = 1'b0;
  int   km_cnt = 0, km_cyc = -1, ovr_cnt = 0, ovr_cyc = -1;
  int   ls_cyc = 0, ovr_exp_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_rotate_scrambler #(.DATA_W(DATA_W), .LINE_LEN(LEN), .KEY_W(KEY_W)) u_a (
    .clk(clk), .reset(reset), .H(h), .V(v), .pix_in(pix_in), .pix_in_valid(pix_in_valid),
    .key(key), .key_valid(key_valid), .mode(mode), .pix_out(pix_out_a),
    .pix_out_valid(pix_out_valid_a), .key_miss(key_miss_a), .line_overrun(line_overrun_a)
  );

  // Descrambler fed directly by the scrambler output.
  line_rotate_scrambler #(.DATA_W(DATA_W), .LINE_LEN(LEN), .KEY_W(KEY_W)) u_b (
    .clk(clk), .reset(reset), .H(h), .V(v), .pix_in(pix_out_a), .pix_in_valid(pix_out_valid_a),
    .key(key), .key_valid(key_valid), .mode(mode_b), .pix_out(pix_out_b),
    .pix_out_valid(pix_out_valid_b), .key_miss(key_miss_b), .line_overrun(line_overrun_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (key_miss_a) begin km_cnt++; km_cyc = cyc; end
    if (line_overrun_a) begin ovr_cnt++; ovr_cyc = cyc; end
    if (pix_out_valid_a) begin
      if (sb_a.size() == 0) check("unexpected_out_a", int'(pix_out_a), -1);
      else begin
        exp_t e;
        e = sb_a.pop_front();
        check("pix_out_a", int'(pix_out_a), e.data);
        check("out_cycle_a", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_b && pix_out_valid_b) begin
      if (sb_b.size() == 0) check("unexpected_out_b", int'(pix_out_b), -1);
      else check("pix_out_b", int'(pix_out_b), sb_b.pop_front());
    end
  end

  task automatic fill_rot(input int base, input int cut);
    for (int j = 0; j < LEN; j++) next_exp.push_back(base + (j + cut) % LEN);
  endtask

  task automatic blank(input logic vv, input logic [7:0] k, input logic kv, input logic md);
    @(posedge clk); #1;
    h = 1'b1; v = vv; pix_in_valid = 1'b0; key = k; key_valid = kv; mode = md;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic active(input int n, input int base);
    exp_t e;
    @(posedge clk); #1;
    h = 1'b0; ls_cyc = cyc + 1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pix_in = DATA_W'(base + i); pix_in_valid = 1'b1;
      if (i == LEN) ovr_exp_cyc = cyc + 1;
      if (next_exp.size() > 0) begin
        e.data = next_exp.pop_front();
        e.cyc  = cyc + 1;
        sb_a.push_back(e);
      end
    end
    @(posedge clk); #1; pix_in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_line(input logic vv, input logic [7:0] k, input logic kv, input logic md,
                          input int n, input int base);
    blank(vv, k, kv, md);
    active(n, base);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix_out"}, int'(pix_out_a), 0);
    check({tag, "_pix_out_valid"}, int'(pix_out_valid_a), 0);
    check({tag, "_key_miss"}, int'(key_miss_a), 0);
    check({tag, "_line_overrun"}, int'(line_overrun_a), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; h = 1'b1; v = 1'b0; pix_in_valid = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    km_cnt = 0; ovr_cnt = 0; next_exp.delete();
  endtask

  task automatic end_test(input string tag);
    repeat (2) @(negedge clk);
    #1;
    check({tag, "_missing_out"}, sb_a.size(), 0);
    sb_a.delete();
  endtask

  initial begin
    // Passthrough: key 0x00 keeps sample order.
    do_reset();
    run_line(1'b0, 8'h00, 1'b1, 1'b0, LEN, 0);
    fill_rot(0, 0);
    run_line(1'b0, 8'h00, 1'b1, 1'b0, LEN, 0);
    end_test("passthrough");

    // Scramble: key 0x40 -> cut 4, then key 0xFF -> cut 15.
    do_reset();
    run_line(1'b0, 8'h40, 1'b1, 1'b0, LEN, 0);
    fill_rot(0, 4);
    run_line(1'b0, 8'h40, 1'b1, 1'b0, LEN, 16);
    fill_rot(16, 15);
    run_line(1'b0, 8'hFF, 1'b1, 1'b0, LEN, 32);
    end_test("scramble");

    // Round trip: key 0xC3 -> cut 12, descrambler restores 0..15.
    do_reset();
    chk_b = 1'b1;
    run_line(1'b0, 8'hC3, 1'b1, 1'b0, LEN, 0);
    fill_rot(0, 12);
    run_line(1'b0, 8'hC3, 1'b1, 1'b0, LEN, 0);
    fill_rot(0, 12);
    for (int j = 0; j < LEN; j++) sb_b.push_back(j);
    run_line(1'b0, 8'hC3, 1'b1, 1'b0, LEN, 0);
    end_test("roundtrip");
    check("roundtrip_missing_out_b", sb_b.size(), 0);
    chk_b = 1'b0;
    sb_b.delete();

    // Key miss: unrotated replay and a single pulse at line start.
    do_reset();
    run_line(1'b0, 8'h40, 1'b1, 1'b0, LEN, 0);
    fill_rot(0, 0);
    run_line(1'b0, 8'h40, 1'b0, 1'b0, LEN, 16);
    check("key_miss_count", km_cnt, 1);
    check("key_miss_cycle", km_cyc, ls_cyc);
    fill_rot(16, 4);
    run_line(1'b0, 8'h40, 1'b1, 1'b0, LEN, 32);
    check("key_miss_count_after", km_cnt, 1);
    end_test("keymiss");

    // Overrun: 20 samples per line, extra samples neither stored nor replayed.
    do_reset();
    run_line(1'b0, 8'h00, 1'b1, 1'b0, 20, 0);
    check("overrun_count", ovr_cnt, 1);
    check("overrun_cycle", ovr_cyc, ovr_exp_cyc);
    fill_rot(0, 0);
    run_line(1'b0, 8'h00, 1'b1, 1'b0, 20, 100);
    check("overrun_count_2", ovr_cnt, 2);
    end_test("overrun");

    // Vertical blanking: output resumes only on the second active line after V falls.
    do_reset();
    run_line(1'b0, 8'h00, 1'b1, 1'b0, LEN, 0);
    fill_rot(0, 0);
    run_line(1'b0, 8'h00, 1'b1, 1'b0, LEN, 16);
    repeat (3) run_line(1'b1, 8'h00, 1'b1, 1'b0, LEN, 40);
    run_line(1'b0, 8'h00, 1'b1, 1'b0, LEN, 80);
    fill_rot(80, 0);
    run_line(1'b0, 8'h00, 1'b1, 1'b0, LEN, 96);
    end_test("vblank");

    // Reset in the middle of a replayed line.
    do_reset();
    run_line(1'b0, 8'h00, 1'b1, 1'b0, LEN, 0);
    blank(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1; h = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      @(posedge clk); #1;
      pix_in = DATA_W'(200 + i); pix_in_valid = 1'b1;
      e.data = i; e.cyc = cyc + 1;
      sb_a.push_back(e);
    end
    @(posedge clk); #1; pix_in = DATA_W'(208);
    @(negedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("midreset");
    check("midreset_pending", sb_a.size(), 0);
    reset = 1'b0; pix_in_valid = 1'b0;
    run_line(1'b0, 8'h00, 1'b1, 1'b0, LEN, 300);
    fill_rot(300, 0);
    run_line(1'b0, 8'h00, 1'b1, 1'b0, LEN, 400);
    end_test("postreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
